multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, with a memory-wait timeout and a sticky trap state.
module multicycle_ctrl #(
   parameter int n   = 32,
   parameter int TMO = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [n-1:0] instr,
   input  logic         BrEq,
   input  logic         BrLT,
   input  logic         mem_ready,
   output logic         mem_req,
   output logic         MEMRW,
   output logic         IRWEn,
   output logic         PCWEn,
   output logic         RegWEn,
   output logic         PCSel,
   output logic         BrUn,
   output logic [1:0]   WBSel,
   output logic [2:0]   state,
   output logic         illegal,
   output logic [n-1:0] retired
);

   localparam int WW = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TMO - 1);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           illegal_q, illegal_d;
   logic [n-1:0]   retired_q, retired_d;

   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic        legal, bad_br, taken;
   logic        unused_ir;

   // Narrow builds zero-extend the instruction so decode logic stays fixed-width.
   assign ir        = 32'(instr);
   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign unused_ir = ^{ir[31:15], ir[11:7]};

   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_ld    = (opcode == 7'b0000011);
   assign is_st    = (opcode == 7'b0100011);
   assign is_br    = (opcode == 7'b1100011);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_jalr  = (opcode == 7'b1100111);
   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);
   assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
   assign bad_br   = is_br & ((funct3 == 3'b010) | (funct3 == 3'b011));

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:          taken = BrEq;
         3'b001:          taken = ~BrEq;
         3'b100, 3'b110:  taken = BrLT;
         3'b101, 3'b111:  taken = ~BrLT;
         default:         taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      mem_req = 1'b0;
      MEMRW   = 1'b0;
      IRWEn   = 1'b0;
      PCWEn   = 1'b0;
      RegWEn  = 1'b0;
      PCSel   = 1'b0;
      BrUn    = 1'b0;
      WBSel   = 2'd1;
      // Outputs are gated by rst_n so nothing pulses while reset is held.
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  IRWEn   = 1'b1;
                  state_d = DECODE;
               end else if (wait_q >= WAIT_LAST) begin
                  state_d = TRAP;
               end else begin
                  wait_d = wait_q + WAIT_ONE;
               end
            end
            DECODE: begin
               state_d = (legal && !bad_br) ? EXEC : TRAP;
            end
            EXEC: begin
               if (is_br) begin
                  PCWEn   = 1'b1;
                  PCSel   = taken;
                  BrUn    = ir[13];
                  state_d = FETCH;
               end else if (is_ld || is_st) begin
                  state_d = MEM;
               end else if (legal) begin
                  state_d = WB;
               end else begin
                  state_d = TRAP;
               end
            end
            MEM: begin
               mem_req = 1'b1;
               MEMRW   = is_st;
               if (mem_ready) begin
                  if (is_st) begin
                     PCWEn   = 1'b1;
                     state_d = FETCH;
                  end else begin
                     state_d = WB;
                  end
               end else if (wait_q >= WAIT_LAST) begin
                  state_d = TRAP;
               end else begin
                  wait_d = wait_q + WAIT_ONE;
               end
            end
            WB: begin
               RegWEn  = 1'b1;
               PCWEn   = 1'b1;
               PCSel   = is_jal | is_jalr;
               WBSel   = is_ld ? 2'd0 : ((is_jal | is_jalr) ? 2'd2 : 2'd1);
               state_d = FETCH;
            end
            TRAP: begin
               state_d = TRAP;
            end
            default: begin
               state_d = TRAP;
            end
         endcase
      end
      illegal_d = illegal_q | (state_d == TRAP);
      retired_d = retired_q + n'(PCWEn);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: a TMO=4 instance for the main
// scenarios and a narrow n=4 instance for the retired-counter wrap.
module tb_multicycle_ctrl;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_LW   = 32'h00012083;
   localparam logic [31:0] I_SW   = 32'h00112223;
   localparam logic [31:0] I_BLTU = {7'd0, 5'd2, 5'd1, 3'b110, 5'b01000, 7'b1100011};
   localparam logic [31:0] I_BEQ  = {7'd0, 5'd2, 5'd1, 3'b000, 5'b01000, 7'b1100011};
   localparam logic [31:0] I_BBAD = {7'd0, 5'd2, 5'd1, 3'b010, 5'b01000, 7'b1100011};
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        BrEq, BrLT, mem_ready;
   logic        mem_req, MEMRW, IRWEn, PCWEn, RegWEn, PCSel, BrUn;
   logic [1:0]  WBSel;
   logic [2:0]  state;
   logic        illegal;
   logic [31:0] retired;

   logic        rst4_n;
   logic [3:0]  instr4;
   logic        ready4;
   logic        mem_req4, MEMRW4, IRWEn4, PCWEn4, RegWEn4, PCSel4, BrUn4;
   logic [1:0]  WBSel4;
   logic [2:0]  state4;
   logic        illegal4;
   logic [3:0]  retired4;

   int nvec = 0;
   int nerr = 0;

   multicycle_ctrl #(.n(32), .TMO(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .BrEq(BrEq), .BrLT(BrLT),
      .mem_ready(mem_ready), .mem_req(mem_req), .MEMRW(MEMRW), .IRWEn(IRWEn),
      .PCWEn(PCWEn), .RegWEn(RegWEn), .PCSel(PCSel), .BrUn(BrUn), .WBSel(WBSel),
      .state(state), .illegal(illegal), .retired(retired)
   );

   multicycle_ctrl #(.n(4), .TMO(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .instr(instr4), .BrEq(1'b0), .BrLT(1'b0),
      .mem_ready(ready4), .mem_req(mem_req4), .MEMRW(MEMRW4), .IRWEn(IRWEn4),
      .PCWEn(PCWEn4), .RegWEn(RegWEn4), .PCSel(PCSel4), .BrUn(BrUn4), .WBSel(WBSel4),
      .state(state4), .illegal(illegal4), .retired(retired4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packs {state, mem_req, MEMRW, IRWEn, PCWEn, RegWEn, PCSel, BrUn, WBSel, illegal}.
   function automatic logic [12:0] ev(input logic [2:0] st, input logic mr, input logic mw,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic pcs, input logic bu, input logic [1:0] wbs,
                                      input logic il);
      return {st, mr, mw, irw, pcw, rw, pcs, bu, wbs, il};
   endfunction

   function automatic logic [12:0] ov();
      return {state, mem_req, MEMRW, IRWEn, PCWEn, RegWEn, PCSel, BrUn, WBSel, illegal};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      BrEq      = 1'b0;
      BrLT      = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] want;
      rst_n = 1'b0; mem_ready = 1'b1; instr = I_ADD; BrEq = 1'b0; BrLT = 1'b0;
      tick(); tick();
      want = ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL reset_outs got %b want %b", ov(), want); end
      nvec++;
      if (retired !== 32'd0) begin nerr++; $display("[TB] FAIL reset_retired got %0d want 0", retired); end
      mem_ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      want = ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL reset_release got %b want %b", ov(), want); end
      tick();
   endtask

   task automatic test_add();
      logic [12:0] want;
      apply_reset();
      instr = I_ADD; mem_ready = 1'b1;
      @(negedge clk);
      want = ev(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL add_fetch got %b want %b", ov(), want); end
      tick(); mem_ready = 1'b0;
      @(negedge clk);
      want = ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL add_decode got %b want %b", ov(), want); end
      tick();
      @(negedge clk);
      want = ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL add_exec got %b want %b", ov(), want); end
      tick();
      @(negedge clk);
      want = ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL add_wb got %b want %b", ov(), want); end
      tick();
      @(negedge clk);
      want = ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL add_refetch got %b want %b", ov(), want); end
      nvec++;
      if (retired !== 32'd1) begin nerr++; $display("[TB] FAIL add_retired got %0d want 1", retired); end
   endtask

   task automatic test_load();
      logic [12:0] want;
      apply_reset();
      instr = I_LW; mem_ready = 1'b1;
      tick(); mem_ready = 1'b0;
      tick();
      @(negedge clk);
      want = ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL lw_exec got %b want %b", ov(), want); end
      tick();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         @(negedge clk);
         want = ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
         nvec++;
         if (ov() !== want) begin nerr++; $display("[TB] FAIL lw_mem%0d got %b want %b", k, ov(), want); end
         tick();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      want = ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL lw_wb got %b want %b", ov(), want); end
      tick();
      nvec++;
      if (retired !== 32'd1) begin nerr++; $display("[TB] FAIL lw_retired got %0d want 1", retired); end
   endtask

   task automatic test_store_jal();
      logic [12:0] want;
      apply_reset();
      instr = I_SW; mem_ready = 1'b1;
      tick(); tick(); tick();
      @(negedge clk);
      want = ev(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL sw_mem got %b want %b", ov(), want); end
      tick();
      instr = I_JAL;
      @(negedge clk);
      nvec++;
      if (state !== 3'd0) begin nerr++; $display("[TB] FAIL sw_next got %0d want 0", state); end
      tick(); tick(); tick();
      @(negedge clk);
      want = ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL jal_wb got %b want %b", ov(), want); end
      tick();
      nvec++;
      if (retired !== 32'd2) begin nerr++; $display("[TB] FAIL sw_jal_retired got %0d want 2", retired); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] want;
      apply_reset();
      instr = I_BLTU; mem_ready = 1'b1; BrLT = 1'b1; BrEq = 1'b0;
      tick(); mem_ready = 1'b0;
      tick();
      @(negedge clk);
      want = ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL bltu_exec got %b want %b", ov(), want); end
      tick();
      instr = I_BEQ; mem_ready = 1'b1; BrLT = 1'b0; BrEq = 1'b0;
      @(negedge clk);
      nvec++;
      if (state !== 3'd0) begin nerr++; $display("[TB] FAIL bltu_next got %0d want 0", state); end
      tick(); mem_ready = 1'b0;
      tick();
      @(negedge clk);
      want = ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL beq_nt_exec got %b want %b", ov(), want); end
      tick();
      nvec++;
      if (retired !== 32'd2) begin nerr++; $display("[TB] FAIL branch_retired got %0d want 2", retired); end
   endtask

   task automatic test_illegal();
      logic [12:0] want;
      apply_reset();
      instr = I_BAD; mem_ready = 1'b1;
      tick(); tick();
      want = ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         mem_ready = k[0];
         @(negedge clk);
         nvec++;
         if (ov() !== want) begin nerr++; $display("[TB] FAIL trap_hold%0d got %b want %b", k, ov(), want); end
         tick();
      end
      rst_n = 1'b0;
      #1;
      want = ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL trap_cleared got %b want %b", ov(), want); end
      apply_reset();
      instr = I_BBAD; mem_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      want = ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL bad_branch got %b want %b", ov(), want); end
   endtask

   task automatic test_timeout();
      logic [12:0] want;
      apply_reset();
      instr = I_ADD; mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         nvec++;
         if (state !== 3'd0) begin nerr++; $display("[TB] FAIL tmo_wait%0d got %0d want 0", k, state); end
         tick();
      end
      @(negedge clk);
      want = ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL tmo_trap got %b want %b", ov(), want); end
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         tick();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      want = ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL tmo_ready_wins got %b want %b", ov(), want); end
   endtask

   task automatic test_reset_mid_access();
      logic [12:0] want;
      apply_reset();
      instr = I_SW; mem_ready = 1'b1;
      tick(); mem_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      nvec++;
      if (state !== 3'd3) begin nerr++; $display("[TB] FAIL mid_in_mem got %0d want 3", state); end
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      want = ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      nvec++;
      if (ov() !== want) begin nerr++; $display("[TB] FAIL mid_abandon got %b want %b", ov(), want); end
      tick();
      nvec++;
      if (retired !== 32'd0) begin nerr++; $display("[TB] FAIL mid_retired got %0d want 0", retired); end
      rst_n = 1'b1;
      mem_ready = 1'b0;
   endtask

   task automatic test_wrap();
      rst4_n = 1'b0; instr4 = 4'b0011; ready4 = 1'b1;
      tick();
      rst4_n = 1'b1;
      for (int k = 0; k < 75; k++) tick();
      @(negedge clk);
      nvec++;
      if (retired4 !== 4'd15) begin nerr++; $display("[TB] FAIL wrap_full got %0d want 15", retired4); end
      nvec++;
      if (state4 !== 3'd0) begin nerr++; $display("[TB] FAIL wrap_state got %0d want 0", state4); end
      for (int k = 0; k < 5; k++) tick();
      @(negedge clk);
      nvec++;
      if (retired4 !== 4'd0) begin nerr++; $display("[TB] FAIL wrap_zero got %0d want 0", retired4); end
   endtask

   initial begin
      rst_n = 1'b0; rst4_n = 1'b0; instr = '0; instr4 = '0;
      BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b0; ready4 = 1'b0;
      test_reset();
      test_add();
      test_load();
      test_store_jal();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_mid_access();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
